// File: rtl/clint_pkg.sv
// clint_pkg: shared definitions for the core-local interrupt/trap controller.
//   - CSR addresses written or read by the controller
//   - instruction encodings recognised in ID (ECALL, EBREAK, MRET)
//   - mcause codes for synchronous traps and asynchronous interrupts
//   - mstatus bit positions and the mstatus update helpers
//   - sequencer state encoding
// Optional feature macro: CLINT_MTVAL_EN (adds the mtval write state).
package clint_pkg;

  // CSR addresses
  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MTVEC   = 32'h0000_0305;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;
  localparam logic [31:0] CSR_MTVAL   = 32'h0000_0343;

  // Instruction encodings
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  // mcause codes
  localparam logic [31:0] CAUSE_ECALL  = 32'h0000_000B;
  localparam logic [31:0] CAUSE_EBREAK = 32'h0000_0003;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;
  localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;

  // mstatus bit indices
  localparam int unsigned MIE_BIT  = 3;
  localparam int unsigned MPIE_BIT = 7;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MEPC    = 3'd1,
    S_MCAUSE  = 3'd2,
    S_MTVAL   = 3'd3,
    S_MSTATUS = 3'd4,
    S_MRET    = 3'd5,
    S_ASSERT  = 3'd6
  } clint_state_e;

  // Trap entry: MPIE takes the current MIE, MIE is cleared.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r           = ms;
    r[MPIE_BIT] = ms[MIE_BIT];
    r[MIE_BIT]  = 1'b0;
    return r;
  endfunction

  // Trap return: MIE restored from MPIE, MPIE set.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r           = ms;
    r[MIE_BIT]  = ms[MPIE_BIT];
    r[MPIE_BIT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/clint_detect.sv
// clint_detect: combinational trap/interrupt decode and priority selection.
// Ports:
//   inst_i, inst_addr_i        instruction in ID and its PC
//   jump_flag_i, jump_addr_i   EX redirect in flight (used as epc for interrupts)
//   int_flag_i                 level requests, [0] timer, [1] external
//   global_int_en_i            mstatus.MIE
//   take_trap_s                start a trap sequence (ECALL/EBREAK/interrupt)
//   take_mret_s                start an MRET sequence
//   cause_s, epc_s             values to latch for the trap sequence
//   is_ebreak_s                trap is an EBREAK (mtval source selection)
// Priority: ECALL/EBREAK > MRET > interrupt; timer > external.
module clint_detect
  import clint_pkg::*;
(
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic [1:0]  int_flag_i,
  input  logic        global_int_en_i,
  output logic        take_trap_s,
  output logic        take_mret_s,
  output logic [31:0] cause_s,
  output logic [31:0] epc_s,
  output logic        is_ebreak_s
);

  logic is_ecall_s;
  logic is_ebrk_s;
  logic is_mret_s;

  assign is_ecall_s = (inst_i == INST_ECALL);
  assign is_ebrk_s  = (inst_i == INST_EBREAK);
  assign is_mret_s  = (inst_i == INST_MRET);

  // Priority decode and cause/epc selection
  always_comb begin
    take_trap_s = 1'b0;
    take_mret_s = 1'b0;
    cause_s     = 32'h0000_0000;
    epc_s       = 32'h0000_0000;
    is_ebreak_s = 1'b0;
    if (is_ecall_s || is_ebrk_s) begin
      take_trap_s = 1'b1;
      cause_s     = is_ebrk_s ? CAUSE_EBREAK : CAUSE_ECALL;
      epc_s       = inst_addr_i;
      is_ebreak_s = is_ebrk_s;
    end else if (is_mret_s) begin
      take_mret_s = 1'b1;
    end else if (global_int_en_i && (int_flag_i != 2'b00)) begin
      take_trap_s = 1'b1;
      cause_s     = int_flag_i[0] ? CAUSE_TIMER : CAUSE_EXT;
      // A taken jump in EX means inst_addr_i is on the squashed path.
      epc_s       = jump_flag_i ? jump_addr_i : inst_addr_i;
    end else begin
      take_trap_s = 1'b0;
    end
  end

endmodule

// File: rtl/clint_ctrl.sv
// clint_ctrl: core-local interrupt/trap controller.
// Detects ECALL/EBREAK/MRET in ID and timer/external interrupts, stalls the
// pipeline, writes the trap CSRs one per cycle through the CLINT write port of
// the CSR file, then redirects the PC to mtvec (trap) or mepc (MRET).
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   inst_i, inst_addr_i    instruction in ID and its PC
//   jump_flag_i/addr_i     EX redirect taken this cycle
//   int_flag_i             level interrupts, [0] timer, [1] external
//   mtvec_i, mepc_i,
//   mstatus_i              CSR values from the register file
//   global_int_en_i        mstatus.MIE
//   we_o/waddr_o/wdata_o   CSR write port (registered)
//   hold_flag_o            pipeline stall request (combinational)
//   int_assert_o/addr_o    one-cycle PC redirect strobe and target (registered)
// Optional feature macro: CLINT_MTVAL_EN inserts an mtval write after mcause.
module clint_ctrl
  import clint_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic [1:0]  int_flag_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mstatus_i,
  input  logic        global_int_en_i,
  output logic        we_o,
  output logic [31:0] waddr_o,
  output logic [31:0] wdata_o,
  output logic        hold_flag_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  clint_state_e state_r;
  clint_state_e next_state_s;

  logic [31:0] cause_r;
  logic [31:0] epc_r;
  logic        ebreak_r;

  logic        take_trap_s;
  logic        take_mret_s;
  logic [31:0] cause_s;
  logic [31:0] epc_s;
  logic        is_ebreak_s;

  // Next values of the registered outputs
  logic        we_n_s;
  logic [31:0] waddr_n_s;
  logic [31:0] wdata_n_s;
  logic        assert_n_s;
  logic [31:0] addr_n_s;

  clint_detect u_detect (
    .inst_i          (inst_i),
    .inst_addr_i     (inst_addr_i),
    .jump_flag_i     (jump_flag_i),
    .jump_addr_i     (jump_addr_i),
    .int_flag_i      (int_flag_i),
    .global_int_en_i (global_int_en_i),
    .take_trap_s     (take_trap_s),
    .take_mret_s     (take_mret_s),
    .cause_s         (cause_s),
    .epc_s           (epc_s),
    .is_ebreak_s     (is_ebreak_s)
  );

  // Stall in the detection cycle (before the FSM leaves IDLE) and throughout a sequence.
  assign hold_flag_o = (state_r == S_IDLE) ? (take_trap_s | take_mret_s) : 1'b1;

  // Next-state and next-output decode; outputs are computed one state ahead
  // so they are registered when the FSM enters the state that owns them.
  always_comb begin
    next_state_s = S_IDLE;
    we_n_s       = 1'b0;
    waddr_n_s    = 32'h0000_0000;
    wdata_n_s    = 32'h0000_0000;
    assert_n_s   = 1'b0;
    addr_n_s     = 32'h0000_0000;
    case (state_r)
      S_IDLE: begin
        if (take_trap_s) begin
          next_state_s = S_MEPC;
          we_n_s       = 1'b1;
          waddr_n_s    = CSR_MEPC;
          wdata_n_s    = epc_s;
        end else if (take_mret_s) begin
          next_state_s = S_MRET;
          we_n_s       = 1'b1;
          waddr_n_s    = CSR_MSTATUS;
          wdata_n_s    = mret_mstatus(mstatus_i);
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_MEPC: begin
        next_state_s = S_MCAUSE;
        we_n_s       = 1'b1;
        waddr_n_s    = CSR_MCAUSE;
        wdata_n_s    = cause_r;
      end
      S_MCAUSE: begin
`ifdef CLINT_MTVAL_EN
        next_state_s = S_MTVAL;
        we_n_s       = 1'b1;
        waddr_n_s    = CSR_MTVAL;
        wdata_n_s    = ebreak_r ? epc_r : 32'h0000_0000;
`else
        next_state_s = S_MSTATUS;
        we_n_s       = 1'b1;
        waddr_n_s    = CSR_MSTATUS;
        wdata_n_s    = trap_mstatus(mstatus_i);
`endif
      end
      S_MTVAL: begin
        next_state_s = S_MSTATUS;
        we_n_s       = 1'b1;
        waddr_n_s    = CSR_MSTATUS;
        wdata_n_s    = trap_mstatus(mstatus_i);
      end
      S_MSTATUS: begin
        next_state_s = S_ASSERT;
        assert_n_s   = 1'b1;
        addr_n_s     = mtvec_i;
      end
      S_MRET: begin
        next_state_s = S_ASSERT;
        assert_n_s   = 1'b1;
        addr_n_s     = mepc_i;
      end
      S_ASSERT: begin
        next_state_s = S_IDLE;
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // State register and registered CSR-write / redirect outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      we_o         <= 1'b0;
      waddr_o      <= 32'h0000_0000;
      wdata_o      <= 32'h0000_0000;
      int_assert_o <= 1'b0;
      int_addr_o   <= 32'h0000_0000;
    end else begin
      state_r      <= next_state_s;
      we_o         <= we_n_s;
      waddr_o      <= waddr_n_s;
      wdata_o      <= wdata_n_s;
      int_assert_o <= assert_n_s;
      int_addr_o   <= addr_n_s;
    end
  end

  // Trap context captured in the detection cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_r  <= 32'h0000_0000;
      epc_r    <= 32'h0000_0000;
      ebreak_r <= 1'b0;
    end else if ((state_r == S_IDLE) && take_trap_s) begin
      cause_r  <= cause_s;
      epc_r    <= epc_s;
      ebreak_r <= is_ebreak_s;
    end else begin
      cause_r  <= cause_r;
      epc_r    <= epc_r;
      ebreak_r <= ebreak_r;
    end
  end

endmodule
